// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared widths, index constants and types for the register file
package regfile_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_ADDR_WIDTH = 5;

    typedef logic [DEFAULT_ADDR_WIDTH-1:0] reg_idx_t;
    typedef logic [DEFAULT_DATA_WIDTH-1:0] word_t;

    localparam reg_idx_t ZERO_REG = '0;

endpackage

// File: rtl/regfile_sync_register.sv
// rtl/regfile_sync_register.sv - one storage word with synchronous clear and write enable
module sync_register #(
    parameter int WIDTH = regfile_pkg::DEFAULT_DATA_WIDTH
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Clear wins over a simultaneous write so a reset edge never commits data.
    always_ff @(posedge clock) begin
        if (clear) begin
            q <= '0;
        end else if (enable) begin
            q <= d;
        end
    end

endmodule

// File: rtl/regfile.sv
// rtl/regfile.sv - 1-write 2-read register file with hardwired zero entry and optional bypass
module regfile
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int BYPASS     = 1
) (
    input  logic                  clock,
    input  logic                  ctrl_reset,
    input  logic                  ctrl_writeEnable,
    input  logic [ADDR_WIDTH-1:0] ctrl_writeReg,
    input  logic [DATA_WIDTH-1:0] data_writeReg,
    input  logic [ADDR_WIDTH-1:0] ctrl_readRegA,
    input  logic [ADDR_WIDTH-1:0] ctrl_readRegB,
    output logic [DATA_WIDTH-1:0] data_readRegA,
    output logic [DATA_WIDTH-1:0] data_readRegB
);

    localparam int DEPTH     = 2 ** ADDR_WIDTH;
    localparam int NUM_READS = 2;

    logic [DEPTH-1:0]                 write_sel;
    logic [DEPTH-1:0][DATA_WIDTH-1:0] entries;
    logic                             write_live;

    logic [NUM_READS-1:0][ADDR_WIDTH-1:0] read_idx;
    logic [NUM_READS-1:0][DATA_WIDTH-1:0] read_data;

    // A write that actually lands this edge; also the only write eligible for forwarding.
    assign write_live = ctrl_writeEnable && !ctrl_reset
                        && (ctrl_writeReg != ADDR_WIDTH'(ZERO_REG));

    always_comb begin
        write_sel = '0;
        if (ctrl_writeEnable) begin
            write_sel[ctrl_writeReg] = 1'b1;
        end
        write_sel[0] = 1'b0;
    end

    assign entries[0] = '0;

    for (genvar i = 1; i < DEPTH; i++) begin : g_entry
        sync_register #(
            .WIDTH (DATA_WIDTH)
        ) u_entry (
            .clock  (clock),
            .clear  (ctrl_reset),
            .enable (write_sel[i]),
            .d      (data_writeReg),
            .q      (entries[i])
        );
    end

    assign read_idx[0]   = ctrl_readRegA;
    assign read_idx[1]   = ctrl_readRegB;
    assign data_readRegA = read_data[0];
    assign data_readRegB = read_data[1];

    for (genvar p = 0; p < NUM_READS; p++) begin : g_read
        logic bypass_hit;

        assign bypass_hit   = (BYPASS != 0) && write_live && (read_idx[p] == ctrl_writeReg);
        assign read_data[p] = bypass_hit ? data_writeReg : entries[read_idx[p]];
    end

endmodule

// File: tb/tb_regfile.sv
// tb/tb_regfile.sv - directed self-checking bench covering bypass and non-bypass builds
module tb_regfile;
    import regfile_pkg::*;

    logic     clock = 1'b0;
    logic     ctrl_reset;
    logic     ctrl_writeEnable;
    reg_idx_t ctrl_writeReg;
    word_t    data_writeReg;
    reg_idx_t ctrl_readRegA;
    reg_idx_t ctrl_readRegB;
    word_t    byp_a, byp_b, raw_a, raw_b;

    int checks = 0;
    int errors = 0;

    regfile #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(1)) u_byp (
        .clock            (clock),
        .ctrl_reset       (ctrl_reset),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg),
        .ctrl_readRegA    (ctrl_readRegA),
        .ctrl_readRegB    (ctrl_readRegB),
        .data_readRegA    (byp_a),
        .data_readRegB    (byp_b)
    );

    regfile #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(0)) u_raw (
        .clock            (clock),
        .ctrl_reset       (ctrl_reset),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg),
        .ctrl_readRegA    (ctrl_readRegA),
        .ctrl_readRegB    (ctrl_readRegB),
        .data_readRegA    (raw_a),
        .data_readRegB    (raw_b)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input word_t got, input word_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_all(input string tag, input word_t exp_byp, input word_t exp_raw);
        #1;
        check({tag, " byp A"}, byp_a, exp_byp);
        check({tag, " byp B"}, byp_b, exp_byp);
        check({tag, " raw A"}, raw_a, exp_raw);
        check({tag, " raw B"}, raw_b, exp_raw);
    endtask

    initial begin
        ctrl_reset       = 1'b1;
        ctrl_writeEnable = 1'b0;
        ctrl_writeReg    = '0;
        data_writeReg    = '0;
        ctrl_readRegA    = '0;
        ctrl_readRegB    = '0;
        tick();
        ctrl_reset = 1'b0;

        // 1: every entry reads zero after reset
        for (int i = 0; i < 32; i++) begin
            ctrl_readRegA = reg_idx_t'(i);
            ctrl_readRegB = reg_idx_t'(31 - i);
            #1;
            check($sformatf("reset r%0d byp A", i), byp_a, 32'h0);
            check($sformatf("reset r%0d byp B", 31 - i), byp_b, 32'h0);
            check($sformatf("reset r%0d raw A", i), raw_a, 32'h0);
            check($sformatf("reset r%0d raw B", 31 - i), raw_b, 32'h0);
        end

        // 2: write r5 and r31 then read back; others untouched
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg    = 5'd5;
        data_writeReg    = 32'hDEADBEEF;
        tick();
        ctrl_writeReg    = 5'd31;
        data_writeReg    = 32'h00000001;
        tick();
        ctrl_writeEnable = 1'b0;
        ctrl_readRegA    = 5'd5;
        ctrl_readRegB    = 5'd31;
        #1;
        check("wr r5 byp", byp_a, 32'hDEADBEEF);
        check("wr r31 byp", byp_b, 32'h00000001);
        check("wr r5 raw", raw_a, 32'hDEADBEEF);
        check("wr r31 raw", raw_b, 32'h00000001);
        for (int i = 0; i < 32; i++) begin
            if (i != 5 && i != 31) begin
                ctrl_readRegA = reg_idx_t'(i);
                #1;
                check($sformatf("untouched r%0d byp", i), byp_a, 32'h0);
                check($sformatf("untouched r%0d raw", i), raw_a, 32'h0);
            end
        end

        // 3: writes to r0 never visible, even through bypass
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg    = 5'd0;
        data_writeReg    = 32'hFFFFFFFF;
        ctrl_readRegA    = 5'd0;
        ctrl_readRegB    = 5'd0;
        check_all("r0 same cycle", 32'h0, 32'h0);
        tick();
        ctrl_writeEnable = 1'b0;
        check_all("r0 after edge", 32'h0, 32'h0);

        // 4: bypass on r7
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg    = 5'd7;
        data_writeReg    = 32'h11111111;
        tick();
        data_writeReg    = 32'h22222222;
        ctrl_readRegA    = 5'd7;
        ctrl_readRegB    = 5'd7;
        check_all("bypass r7 same cycle", 32'h22222222, 32'h11111111);
        tick();
        ctrl_writeEnable = 1'b0;
        check_all("bypass r7 after edge", 32'h22222222, 32'h22222222);

        // 5: reset collides with a write to r3
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg    = 5'd3;
        data_writeReg    = 32'h55555555;
        tick();
        ctrl_reset       = 1'b1;
        data_writeReg    = 32'hABCD0000;
        ctrl_readRegA    = 5'd3;
        ctrl_readRegB    = 5'd3;
        check_all("reset+write no bypass", 32'h55555555, 32'h55555555);
        tick();
        ctrl_reset       = 1'b0;
        ctrl_writeEnable = 1'b0;
        check_all("reset+write r3 after", 32'h0, 32'h0);
        ctrl_readRegA    = 5'd5;
        ctrl_readRegB    = 5'd7;
        #1;
        check("reset cleared r5", byp_a, 32'h0);
        check("reset cleared r7", raw_b, 32'h0);

        // 6: write enable low holds r9
        ctrl_writeEnable = 1'b0;
        ctrl_writeReg    = 5'd9;
        data_writeReg    = 32'h12345678;
        ctrl_readRegA    = 5'd9;
        ctrl_readRegB    = 5'd9;
        check_all("we low same cycle", 32'h0, 32'h0);
        repeat (4) tick();
        check_all("we low after 4 edges", 32'h0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile.md
Name: regfile

Overview:
- Multi-ported architectural register file: the read side of processor register storage.
- One write port and two independent read ports, feeding decode/operand fetch.
- Register 0 is hardwired to zero.
- Optional write-to-read bypass, so a value written in cycle N is visible to a same-cycle read.

Parameters:
- DATA_WIDTH, 32, bits per register.
- ADDR_WIDTH, 5, register index width; depth = 2**ADDR_WIDTH.
- BYPASS, 1, 1 = same-cycle write forwarded to read ports; 0 = reads see the pre-edge value.

Ports:
- clock  input  1  single system clock, rising-edge active.
- ctrl_reset  input  1  synchronous, active-high reset.
- ctrl_writeEnable  input  1  commit data_writeReg to ctrl_writeReg on this rising edge.
- ctrl_writeReg  input  ADDR_WIDTH  write index.
- data_writeReg  input  DATA_WIDTH  write data.
- ctrl_readRegA  input  ADDR_WIDTH  read index, port A.
- ctrl_readRegB  input  ADDR_WIDTH  read index, port B.
- data_readRegA  output  DATA_WIDTH  port A read data.
- data_readRegB  output  DATA_WIDTH  port B read data.

Interface rules:
- One clock, named clock.
- Reset is synchronous and active-high, named ctrl_reset.

Behaviour:
- Storage: 2**ADDR_WIDTH entries, each DATA_WIDTH bits, updated only on the rising edge of clock.
- Reset: ctrl_reset high at a rising edge clears every entry to 0. Reset takes priority over a simultaneous write, which is dropped. Reset has no asynchronous effect: between edges, contents hold.
- Outputs during reset: reads are combinational, so the outputs show stored contents. They become 0 one edge after reset is sampled. With BYPASS=1 and ctrl_reset high, bypass is suppressed.
- Write: ctrl_writeEnable=1 and ctrl_reset=0 at the edge stores data_writeReg into entry ctrl_writeReg. Other entries hold. Write latency is 1 edge.
- Entry 0: writes to index 0 are discarded. Reads of index 0 always return 0, including via bypass.
- Read: combinational, zero latency; data_readRegX = entry[ctrl_readRegX].
- Bypass (BYPASS=1): if ctrl_writeEnable=1, ctrl_reset=0, ctrl_writeReg!=0 and ctrl_readRegX==ctrl_writeReg, then data_readRegX = data_writeReg in the same cycle.
- No bypass (BYPASS=0): reads return the stored value; new data appears after the edge.
- Both ports may address the same index, and both return the identical value.
- Index range is exactly the depth, so there are no out-of-range indices and no wrap-around behaviour.
- Output value after reset: both read outputs are 0 for every index.
- No X propagation is allowed: undriven or uninitialised storage before the first reset is not permitted to reach outputs after reset.

Decomposition:
- Shared package holds:
  - DATA_WIDTH and ADDR_WIDTH defaults.
  - The ZERO_REG index constant (0).
  - A reg_idx_t typedef (ADDR_WIDTH bits).
  - A word_t typedef (DATA_WIDTH bits).
- One natural sub-module, sync_register: DATA_WIDTH-bit register with synchronous active-high clear and write enable.
  - Instantiated once per entry 1..depth-1.
- The write-index one-hot decoder stays inline in regfile.
- Read muxes and bypass compare/select stay inline in regfile, as a generate loop per port.

Test Plan:
1. Reset then read all entries:
   - Stimulus: pulse ctrl_reset for 1 edge; sweep ctrl_readRegA and ctrl_readRegB over 0..31.
   - Required: both outputs 0 for every index.
2. Write/readback:
   - Stimulus: write 0xDEADBEEF to r5 and 0x00000001 to r31 on consecutive edges; then read A=5, B=31.
   - Required: 0xDEADBEEF and 0x00000001; all other entries are still 0.
3. Zero register:
   - Stimulus: write 0xFFFFFFFF to r0; read A=0 and B=0 both in the write cycle and after the edge.
   - Required: 0 in both cycles, under both BYPASS settings.
4. Bypass:
   - Stimulus: r7 holds 0x11111111; write 0x22222222 to r7 while A=7 and B=7.
   - Required with BYPASS=1: both read 0x22222222 in that cycle.
   - Required with BYPASS=0: 0x11111111 in that cycle, then 0x22222222 after the edge.
5. Reset vs write collision:
   - Stimulus: ctrl_reset=1 and a write of 0xABCD0000 to r3 at the same edge.
   - Required: r3 reads 0 after the edge, and there is no bypass during that cycle.
6. Write enable low:
   - Stimulus: ctrl_writeEnable=0, ctrl_writeReg=9, data_writeReg=0x12345678 for 4 edges.
   - Required: r9 keeps its prior value (0 after reset).
